// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional write-to-read
// bypass and a per-register busy bit used by the control unit to stall on pending results.
module regfile_scoreboard #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        ra_addr,
  input  logic [ADDR_W-1:0]        rb_addr,
  output logic [DATA_W-1:0]        ra_data,
  output logic [DATA_W-1:0]        rb_data,
  output logic                     ra_busy,
  output logic                     rb_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic              ra_hit, rb_hit;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Reserve is applied after release so a same-edge write+reserve leaves the bit set;
  // flush wins over both.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    ra_hit = (BYPASS != 0) && wr_en && (wr_addr == ra_addr);
    rb_hit = (BYPASS != 0) && wr_en && (wr_addr == rb_addr);
  end

  always_comb begin
    ra_data = ra_hit ? wr_data : mem_q[ra_addr];
    ra_busy = ra_hit ? 1'b0    : busy_q[ra_addr];
    rb_data = rb_hit ? wr_data : mem_q[rb_addr];
    rb_busy = rb_hit ? 1'b0    : busy_q[rb_addr];
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: bypassing and non-bypassing instances share stimulus and are
// checked against an array model of the register contents and busy bits.
module tb_regfile_scoreboard;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          run = 1'b0;
  logic          rst;
  logic [AW-1:0] ra_addr, rb_addr, wr_addr, rsv_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, rsv_en, flush;

  logic [DW-1:0] ra_data_b, rb_data_b, ra_data_n, rb_data_n;
  logic          ra_busy_b, rb_busy_b, ra_busy_n, rb_busy_n;
  logic [D-1:0]  busy_vec_b, busy_vec_n;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [DW-1:0] m_mem  [D];
  logic          m_busy [D];

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_data  (ra_data_b),
    .rb_data  (rb_data_b),
    .ra_busy  (ra_busy_b),
    .rb_busy  (rb_busy_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .busy_vec (busy_vec_b)
  );

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nb (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_data  (ra_data_n),
    .rb_data  (rb_data_n),
    .ra_busy  (ra_busy_n),
    .rb_busy  (rb_busy_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .busy_vec (busy_vec_n)
  );

  initial begin
    wait (run);
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i]  = DW'(i);
      m_busy[i] = 1'b0;
    end
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic model_edge();
    if (wr_en) m_mem[wr_addr] = wr_data;
    if (flush) begin
      for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
    end else begin
      if (wr_en)  m_busy[wr_addr]  = 1'b0;
      if (rsv_en) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input bit byp, input logic [AW-1:0] a);
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [AW-1:0] a);
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [D-1:0] exp_vec();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".a_data_byp"}, 32'(ra_data_b), 32'(exp_data(1'b1, ra_addr)));
    chk({tag, ".b_data_byp"}, 32'(rb_data_b), 32'(exp_data(1'b1, rb_addr)));
    chk({tag, ".a_busy_byp"}, 32'(ra_busy_b), 32'(exp_busy(1'b1, ra_addr)));
    chk({tag, ".b_busy_byp"}, 32'(rb_busy_b), 32'(exp_busy(1'b1, rb_addr)));
    chk({tag, ".a_data_nb"},  32'(ra_data_n), 32'(exp_data(1'b0, ra_addr)));
    chk({tag, ".b_data_nb"},  32'(rb_data_n), 32'(exp_data(1'b0, rb_addr)));
    chk({tag, ".a_busy_nb"},  32'(ra_busy_n), 32'(exp_busy(1'b0, ra_addr)));
    chk({tag, ".b_busy_nb"},  32'(rb_busy_n), 32'(exp_busy(1'b0, rb_addr)));
    chk({tag, ".vec_byp"},    32'(busy_vec_b), 32'(exp_vec()));
    chk({tag, ".vec_nb"},     32'(busy_vec_n), 32'(exp_vec()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ra_addr = '0; rb_addr = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
    idle_inputs();
    model_reset();
    #2;
    // Reset contents visible with no clock running.
    for (int a = 0; a < D; a++) begin
      ra_addr = AW'(a);
      rb_addr = AW'(D - 1 - a);
      #1;
      check_all("reset");
      chk("reset.lit_a", 32'(ra_data_b), a);
      chk("reset.lit_b", 32'(rb_data_n), D - 1 - a);
    end
    chk("reset.vec_lit", 32'(busy_vec_b), 0);
    rst = 1'b0;
    #1;
    run = 1'b1;
    @(negedge clk);

    // Write then read, bypass vs stored-only.
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'hA; ra_addr = 2'd2; rb_addr = 2'd0;
    #1;
    check_all("wr_pre");
    chk("wr_pre.byp_lit", 32'(ra_data_b), 32'hA);
    chk("wr_pre.nb_lit", 32'(ra_data_n), 32'h2);
    tick();
    idle_inputs();
    #1;
    check_all("wr_post");
    chk("wr_post.byp_lit", 32'(ra_data_b), 32'hA);
    chk("wr_post.nb_lit", 32'(ra_data_n), 32'hA);

    // Reserve then release by write.
    rsv_en = 1'b1; rsv_addr = 2'd3;
    #1;
    check_all("rsv_issue");
    tick();
    idle_inputs();
    ra_addr = 2'd3;
    #1;
    check_all("rsv_vis");
    chk("rsv_vis.vec_lit", 32'(busy_vec_b), 32'b1000);
    chk("rsv_vis.busy_lit", 32'(ra_busy_b), 1);
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'h5;
    #1;
    check_all("rel_issue");
    chk("rel_issue.busy_byp", 32'(ra_busy_b), 0);
    chk("rel_issue.data_byp", 32'(ra_data_b), 32'h5);
    chk("rel_issue.busy_nb", 32'(ra_busy_n), 1);
    tick();
    idle_inputs();
    #1;
    check_all("rel_done");
    chk("rel_done.vec_lit", 32'(busy_vec_b), 0);

    // Same-edge write and reserve, then flush beating a reserve.
    rsv_en = 1'b1; rsv_addr = 2'd1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'hF;
    tick();
    idle_inputs();
    ra_addr = 2'd1;
    #1;
    check_all("collide");
    chk("collide.data_lit", 32'(ra_data_n), 32'hF);
    chk("collide.vec_lit", 32'(busy_vec_b), 32'b0010);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 2'd0;
    #1;
    check_all("flush_issue");
    chk("flush_issue.busy_lit", 32'(ra_busy_b), 1);
    tick();
    idle_inputs();
    #1;
    check_all("flush_done");
    chk("flush_done.vec_lit", 32'(busy_vec_n), 0);

    // Dual port, same and different addresses.
    rsv_en = 1'b1; rsv_addr = 2'd1;
    tick();
    idle_inputs();
    ra_addr = 2'd1; rb_addr = 2'd1;
    #1;
    check_all("dual_same");
    chk("dual_same.a_busy", 32'(ra_busy_b), 1);
    chk("dual_same.b_busy", 32'(rb_busy_b), 1);
    chk("dual_same.b_data", 32'(rb_data_b), 32'hF);
    ra_addr = 2'd0; rb_addr = 2'd3;
    #1;
    check_all("dual_diff");
    chk("dual_diff.a_data", 32'(ra_data_b), 32'h0);
    chk("dual_diff.b_data", 32'(rb_data_b), 32'h5);

    // Async reset between edges drops reservations and restores index values.
    rsv_en = 1'b1; rsv_addr = 2'd0;
    tick();
    rsv_addr = 2'd2;
    tick();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h7;
    tick();
    idle_inputs();
    #1;
    check_all("pre_rst");
    rst = 1'b1;
    model_reset();
    ra_addr = 2'd1; rb_addr = 2'd2;
    #1;
    check_all("mid_rst");
    chk("mid_rst.vec_lit", 32'(busy_vec_b), 0);
    chk("mid_rst.r1_lit", 32'(ra_data_b), 1);
    chk("mid_rst.r2_lit", 32'(rb_data_n), 2);
    rst = 1'b0;
    #1;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h9;
    tick();
    idle_inputs();
    #1;
    check_all("post_rst");
    chk("post_rst.wr_lit", 32'(ra_data_n), 32'h9);

    // Randomized traffic with occasional asynchronous reset pulses.
    repeat (400) begin
      ra_addr  = AW'($urandom_range(D - 1));
      rb_addr  = AW'($urandom_range(D - 1));
      wr_addr  = AW'($urandom_range(D - 1));
      rsv_addr = AW'($urandom_range(D - 1));
      wr_data  = DW'($urandom);
      wr_en    = ($urandom_range(1) == 1);
      rsv_en   = ($urandom_range(1) == 1);
      flush    = ($urandom_range(7) == 0);
      if ($urandom_range(39) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
      end
      #1;
      check_all("rand");
      tick();
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
